// File: rtl/usb_pkg.sv
// Shared USB receive definitions: PID codes, decoder state encoding, CRC5 seed.
// Helpers for PID validation and token classification.
package usb_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam logic [4:0] CRC5_INIT = 5'h1f;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PID,
        ST_TOK0,
        ST_TOK1,
        ST_EOP,
        ST_DRAIN
    } rx_state_t;

    function automatic logic pid_ok(input logic [7:0] pid_byte);
        return pid_byte[7:4] == ~pid_byte[3:0];
    endfunction

    function automatic logic is_token(input logic [3:0] pid);
        return (pid == PID_OUT) || (pid == PID_IN) || (pid == PID_SETUP) || (pid == PID_SOF);
    endfunction

endpackage

// File: rtl/crc5.sv
// USB CRC5 (x^5+x^2+1) over 11 bits, d[10] processed first; purely combinational.
// No latency, no flow control.
module crc5 (
    input  logic [4:0]  i_c,
    input  logic [10:0] i_d,
    output logic [4:0]  o_c
);

    logic [4:0] w_crc;
    logic       w_fb;

    always_comb begin
        w_crc = i_c;
        w_fb  = 1'b0;
        for (int i = 10; i >= 0; i--) begin
            w_fb  = w_crc[4] ^ i_d[i];
            w_crc = {w_crc[3:0], 1'b0} ^ (w_fb ? 5'b00101 : 5'b00000);
        end
    end

    assign o_c = w_crc;

endmodule

// File: rtl/usb_token_rx.sv
// Token decoder: PID + 2 bytes -> PID/ADDR/ENDP or SOF frame; strobes 1 cycle after EOP.
// No backpressure: every valid byte is consumed; non-token packets are drained.
module usb_token_rx
    import usb_pkg::*;
#(
    parameter int unsigned RX_TIMEOUT = 255,
    parameter bit          CHECK_ADDR = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_active,
    input  logic        rx_err,
    input  logic [6:0]  dev_addr,
    output logic [3:0]  token_pid,
    output logic [6:0]  token_addr,
    output logic [3:0]  token_endp,
    output logic [10:0] frame_no,
    output logic        token_valid,
    output logic        sof_valid,
    output logic        crc5_err,
    output logic        pid_err,
    output logic        rx_abort
);

    localparam logic [15:0] TIMEOUT_LIM = 16'(RX_TIMEOUT);

    rx_state_t   r_state, w_next;
    logic [7:0]  r_tok0, r_tok1;
    logic [3:0]  r_pid;
    logic [15:0] r_cnt;
    logic        w_abort, w_pid_err, w_eval, w_ld_pid, w_ld_tok0, w_ld_tok1;
    logic [10:0] w_crc_d;
    logic [4:0]  w_crc_out, w_crc_exp;
    logic        w_crc_ok;

    logic [3:0]  r_token_pid;
    logic [6:0]  r_token_addr;
    logic [3:0]  r_token_endp;
    logic [10:0] r_frame_no;
    logic        r_token_valid, r_sof_valid, r_crc5_err, r_pid_err, r_rx_abort;

    // Wire order: tok0 LSB goes out first, so it is the first bit into the CRC.
    assign w_crc_d   = {r_tok0[0], r_tok0[1], r_tok0[2], r_tok0[3], r_tok0[4], r_tok0[5],
                        r_tok0[6], r_tok0[7], r_tok1[0], r_tok1[1], r_tok1[2]};
    assign w_crc_exp = ~{w_crc_out[0], w_crc_out[1], w_crc_out[2], w_crc_out[3], w_crc_out[4]};
    assign w_crc_ok  = (w_crc_exp == r_tok1[7:3]);

    crc5 u_crc5 (
        .i_c (CRC5_INIT),
        .i_d (w_crc_d),
        .o_c (w_crc_out)
    );

    always_comb begin
        w_next    = r_state;
        w_abort   = 1'b0;
        w_pid_err = 1'b0;
        w_eval    = 1'b0;
        w_ld_pid  = 1'b0;
        w_ld_tok0 = 1'b0;
        w_ld_tok1 = 1'b0;
        case (r_state)
            ST_IDLE:  if (rx_active) w_next = ST_PID;
            ST_DRAIN: if (!rx_active) w_next = ST_IDLE;
            default: begin
                if (rx_err) begin
                    w_abort = 1'b1;
                    w_next  = rx_active ? ST_DRAIN : ST_IDLE;
                end else if (!rx_active) begin
                    w_eval  = (r_state == ST_EOP);
                    w_abort = (r_state != ST_EOP);
                    w_next  = ST_IDLE;
                end else if (r_cnt == TIMEOUT_LIM) begin
                    w_abort = 1'b1;
                    w_next  = ST_DRAIN;
                end else if (rx_valid) begin
                    case (r_state)
                        ST_PID: begin
                            if (!pid_ok(rx_data)) begin
                                w_pid_err = 1'b1;
                                w_next    = ST_DRAIN;
                            end else begin
                                w_ld_pid = 1'b1;
                                w_next   = is_token(rx_data[3:0]) ? ST_TOK0 : ST_DRAIN;
                            end
                        end
                        ST_TOK0: begin
                            w_ld_tok0 = 1'b1;
                            w_next    = ST_TOK1;
                        end
                        ST_TOK1: begin
                            w_ld_tok1 = 1'b1;
                            w_next    = ST_EOP;
                        end
                        default: begin
                            w_abort = 1'b1;
                            w_next  = ST_DRAIN;
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_tok0  <= '0;
            r_tok1  <= '0;
            r_pid   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_ld_pid)  r_pid  <= rx_data[3:0];
            if (w_ld_tok0) r_tok0 <= rx_data;
            if (w_ld_tok1) r_tok1 <= rx_data;
            if (r_state == ST_IDLE)      r_cnt <= '0;
            else if (r_cnt != TIMEOUT_LIM) r_cnt <= r_cnt + 16'd1;
        end
    end

    // Fields move only on a CRC-clean packet; the address filter gates the strobe alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_token_pid   <= '0;
            r_token_addr  <= '0;
            r_token_endp  <= '0;
            r_frame_no    <= '0;
            r_token_valid <= 1'b0;
            r_sof_valid   <= 1'b0;
            r_crc5_err    <= 1'b0;
            r_pid_err     <= 1'b0;
            r_rx_abort    <= 1'b0;
        end else begin
            r_token_valid <= 1'b0;
            r_sof_valid   <= 1'b0;
            r_crc5_err    <= 1'b0;
            r_pid_err     <= w_pid_err;
            r_rx_abort    <= w_abort;
            if (w_eval) begin
                if (!w_crc_ok) begin
                    r_crc5_err <= 1'b1;
                end else if (r_pid == PID_SOF) begin
                    r_frame_no  <= {r_tok1[2:0], r_tok0};
                    r_sof_valid <= 1'b1;
                end else begin
                    r_token_pid   <= r_pid;
                    r_token_addr  <= r_tok0[6:0];
                    r_token_endp  <= {r_tok1[2:0], r_tok0[7]};
                    r_token_valid <= !CHECK_ADDR || (r_tok0[6:0] == dev_addr);
                end
            end
        end
    end

    assign token_pid   = r_token_pid;
    assign token_addr  = r_token_addr;
    assign token_endp  = r_token_endp;
    assign frame_no    = r_frame_no;
    assign token_valid = r_token_valid;
    assign sof_valid   = r_sof_valid;
    assign crc5_err    = r_crc5_err;
    assign pid_err     = r_pid_err;
    assign rx_abort    = r_rx_abort;

endmodule

// File: tb/tb_usb_token_rx.sv
// Directed bench: a vector table of token/non-token packets plus hand sequences
// for rx_err, timeout and mid-packet reset; one address-filtering and one unfiltered DUT.
module tb_usb_token_rx;

    localparam int TO = 30;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_active, rx_err;
    logic [6:0]  dev_addr;
    logic [3:0]  token_pid, token_endp, na_pid, na_endp;
    logic [6:0]  token_addr, na_addr;
    logic [10:0] frame_no, na_frame;
    logic        token_valid, sof_valid, crc5_err, pid_err, rx_abort;
    logic        na_tv, na_sof, na_crc, na_perr, na_ab;

    always #5 clk = ~clk;

    usb_token_rx #(.RX_TIMEOUT(TO), .CHECK_ADDR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_active(rx_active), .rx_err(rx_err), .dev_addr(dev_addr),
        .token_pid(token_pid), .token_addr(token_addr), .token_endp(token_endp),
        .frame_no(frame_no), .token_valid(token_valid), .sof_valid(sof_valid),
        .crc5_err(crc5_err), .pid_err(pid_err), .rx_abort(rx_abort)
    );

    usb_token_rx #(.RX_TIMEOUT(TO), .CHECK_ADDR(1'b0)) dut_na (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_active(rx_active), .rx_err(rx_err), .dev_addr(dev_addr),
        .token_pid(na_pid), .token_addr(na_addr), .token_endp(na_endp),
        .frame_no(na_frame), .token_valid(na_tv), .sof_valid(na_sof),
        .crc5_err(na_crc), .pid_err(na_perr), .rx_abort(na_ab)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Cumulative strobe counters; scenarios compare deltas against a snapshot.
    int n_tv = 0, n_tv_na = 0, n_sof = 0, n_crc = 0, n_perr = 0, n_ab = 0;
    int s_tv, s_tv_na, s_sof, s_crc, s_perr, s_ab;

    always @(negedge clk) begin
        if (token_valid) n_tv++;
        if (na_tv)       n_tv_na++;
        if (sof_valid)   n_sof++;
        if (crc5_err)    n_crc++;
        if (pid_err)     n_perr++;
        if (rx_abort)    n_ab++;
    end

    typedef struct {
        string       name;
        logic [6:0]  dev;
        logic [31:0] bytes;
        int          n;
        int          tv, tv_na, sof, crc, perr, ab;
        logic [3:0]  pid;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic [10:0] frame;
    } vec_t;

    localparam int NV = 13;
    vec_t vt[NV];

    function automatic logic [31:0] pk(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3);
        return {b3, b2, b1, b0};
    endfunction

    function automatic vec_t mk(input string nm, input logic [6:0] dev, input logic [31:0] by,
                                input int n, input int tv, input int tvna, input int sof,
                                input int crc, input int perr, input int ab, input logic [3:0] pid,
                                input logic [6:0] addr, input logic [3:0] endp, input logic [10:0] fr);
        vec_t v;
        v.name = nm; v.dev = dev; v.bytes = by; v.n = n;
        v.tv = tv; v.tv_na = tvna; v.sof = sof; v.crc = crc; v.perr = perr; v.ab = ab;
        v.pid = pid; v.addr = addr; v.endp = endp; v.frame = fr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        s_tv = n_tv; s_tv_na = n_tv_na; s_sof = n_sof; s_crc = n_crc; s_perr = n_perr; s_ab = n_ab;
    endtask

    task automatic chk_deltas(input string nm, input int tv, input int tvna, input int sof,
                              input int crc, input int perr, input int ab);
        chk({nm, ".token_valid"}, 32'(n_tv - s_tv), 32'(tv));
        chk({nm, ".token_valid_na"}, 32'(n_tv_na - s_tv_na), 32'(tvna));
        chk({nm, ".sof_valid"}, 32'(n_sof - s_sof), 32'(sof));
        chk({nm, ".crc5_err"}, 32'(n_crc - s_crc), 32'(crc));
        chk({nm, ".pid_err"}, 32'(n_perr - s_perr), 32'(perr));
        chk({nm, ".rx_abort"}, 32'(n_ab - s_ab), 32'(ab));
    endtask

    task automatic chk_fields(input string nm, input logic [3:0] pid, input logic [6:0] addr,
                              input logic [3:0] endp, input logic [10:0] fr);
        chk({nm, ".token_pid"}, 32'(token_pid), 32'(pid));
        chk({nm, ".token_addr"}, 32'(token_addr), 32'(addr));
        chk({nm, ".token_endp"}, 32'(token_endp), 32'(endp));
        chk({nm, ".frame_no"}, 32'(frame_no), 32'(fr));
    endtask

    // Ends in the cycle right after rx_active was first sampled low (strobe cycle).
    task automatic send_pkt(input logic [31:0] by, input int n);
        tick(); rx_active = 1'b1; rx_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick(); rx_valid = 1'b1; rx_data = by[8*i +: 8];
        end
        tick(); rx_valid = 1'b0; rx_data = 8'h00;
        tick(); rx_active = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic got;

        vt[0]  = mk("out_a5_ep1",  7'h05, pk(8'hE1, 8'h85, 8'h60, 8'h00), 3, 1,1,0,0,0,0, 4'h1, 7'h05, 4'h1, 11'h000);
        vt[1]  = mk("setup_badcrc",7'h00, pk(8'h2D, 8'h00, 8'h11, 8'h00), 3, 0,0,0,1,0,0, 4'h1, 7'h05, 4'h1, 11'h000);
        vt[2]  = mk("setup_a0",    7'h00, pk(8'h2D, 8'h00, 8'h10, 8'h00), 3, 1,1,0,0,0,0, 4'hD, 7'h00, 4'h0, 11'h000);
        vt[3]  = mk("in_filtered", 7'h05, pk(8'h69, 8'h00, 8'h10, 8'h00), 3, 0,1,0,0,0,0, 4'h9, 7'h00, 4'h0, 11'h000);
        vt[4]  = mk("sof_1",       7'h05, pk(8'hA5, 8'h01, 8'hE8, 8'h00), 3, 0,0,1,0,0,0, 4'h9, 7'h00, 4'h0, 11'h001);
        vt[5]  = mk("sof_badcrc",  7'h05, pk(8'hA5, 8'h01, 8'hE9, 8'h00), 3, 0,0,0,1,0,0, 4'h9, 7'h00, 4'h0, 11'h001);
        vt[6]  = mk("pid_bad",     7'h05, pk(8'h2E, 8'h00, 8'h10, 8'h00), 3, 0,0,0,0,1,0, 4'h9, 7'h00, 4'h0, 11'h001);
        vt[7]  = mk("ack",         7'h05, pk(8'hD2, 8'h00, 8'h00, 8'h00), 1, 0,0,0,0,0,0, 4'h9, 7'h00, 4'h0, 11'h001);
        vt[8]  = mk("data0",       7'h05, pk(8'hC3, 8'h00, 8'h00, 8'h00), 3, 0,0,0,0,0,0, 4'h9, 7'h00, 4'h0, 11'h001);
        vt[9]  = mk("len4",        7'h00, pk(8'h2D, 8'h00, 8'h10, 8'h55), 4, 0,0,0,0,0,1, 4'h9, 7'h00, 4'h0, 11'h001);
        vt[10] = mk("len2",        7'h00, pk(8'h2D, 8'h00, 8'h00, 8'h00), 2, 0,0,0,0,0,1, 4'h9, 7'h00, 4'h0, 11'h001);
        vt[11] = mk("len1",        7'h00, pk(8'h2D, 8'h00, 8'h00, 8'h00), 1, 0,0,0,0,0,1, 4'h9, 7'h00, 4'h0, 11'h001);
        vt[12] = mk("len0",        7'h00, pk(8'h00, 8'h00, 8'h00, 8'h00), 0, 0,0,0,0,0,1, 4'h9, 7'h00, 4'h0, 11'h001);

        rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_active = 1'b0; rx_err = 1'b0; dev_addr = 7'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_fields("reset", 4'h0, 7'h00, 4'h0, 11'h000);
        chk("reset.strobes", {27'd0, token_valid, sof_valid, crc5_err, pid_err, rx_abort}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            dev_addr = vt[i].dev;
            snap();
            send_pkt(vt[i].bytes, vt[i].n);
            chk({vt[i].name, ".tv_at_eop+1"}, 32'(token_valid), 32'(vt[i].tv));
            tick();
            chk({vt[i].name, ".tv_one_cycle"}, 32'(token_valid), 32'd0);
            tick();
            chk_deltas(vt[i].name, vt[i].tv, vt[i].tv_na, vt[i].sof, vt[i].crc, vt[i].perr, vt[i].ab);
            chk_fields(vt[i].name, vt[i].pid, vt[i].addr, vt[i].endp, vt[i].frame);
        end

        // rx_err in TOK0 (with a simultaneous byte), then again while draining.
        snap();
        tick(); rx_active = 1'b1;
        tick(); rx_valid = 1'b1; rx_data = 8'h2D;
        tick(); rx_data = 8'h00; rx_err = 1'b1;
        tick(); rx_err = 1'b0; rx_data = 8'h10;
        tick(); rx_valid = 1'b0;
        tick(); rx_err = 1'b1;
        tick(); rx_err = 1'b0;
        tick(); rx_active = 1'b0;
        repeat (3) tick();
        chk_deltas("rx_err", 0, 0, 0, 0, 0, 1);
        chk_fields("rx_err", 4'h9, 7'h00, 4'h0, 11'h001);

        // Timeout: stuck in TOK1 with rx_active high.
        snap();
        got = 1'b0; k = -1;
        tick(); rx_active = 1'b1;
        tick(); rx_valid = 1'b1; rx_data = 8'h2D;
        tick(); rx_data = 8'h00;
        tick(); rx_valid = 1'b0;
        for (int c = 0; c < TO + 10; c++) begin
            tick();
            if (!got && rx_abort) begin
                got = 1'b1;
                k = c;
            end
        end
        chk("timeout.seen", 32'(got), 32'd1);
        chk("timeout.when", 32'((k >= TO - 3) && (k <= TO - 1)), 32'd1);
        repeat (2 * TO) tick();
        rx_active = 1'b0;
        repeat (3) tick();
        chk_deltas("timeout", 0, 0, 0, 0, 0, 1);

        // Async reset while waiting in TOK1.
        tick(); rx_active = 1'b1;
        tick(); rx_valid = 1'b1; rx_data = 8'h2D;
        tick(); rx_data = 8'h00;
        tick(); rx_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk_fields("midreset", 4'h0, 7'h00, 4'h0, 11'h000);
        chk("midreset.strobes", {27'd0, token_valid, sof_valid, crc5_err, pid_err, rx_abort}, 32'd0);
        rx_active = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        dev_addr = 7'h05;
        snap();
        send_pkt(pk(8'hE1, 8'h85, 8'h60, 8'h00), 3);
        chk("after_reset.tv_at_eop+1", 32'(token_valid), 32'd1);
        repeat (2) tick();
        chk_deltas("after_reset", 1, 1, 0, 0, 0, 0);
        chk_fields("after_reset", 4'h1, 7'h05, 4'h1, 11'h000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
